zap_cp_dispatch: RTL

//  Issue-side coprocessor dispatcher: sits directly upstream of the CP15 control block.

---
 rtl/zap_cp_dispatch.sv | 135 +++++++++++++
 1 files changed

// File: rtl/zap_cp_dispatch.sv
// Issue-side coprocessor dispatcher.
// Catches MCR/MRC in the issue stage, freezes the pipeline and holds the
// instruction on the coprocessor bus until the coprocessor answers with
// i_cp_done. Absent coprocessors, CDP/LDC/STC and bus timeouts become a
// one-cycle undefined-instruction pulse.
module zap_cp_dispatch #(
  parameter logic [15:0] CP_MASK = 16'h8000,
  parameter int          TIMEOUT = 32
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_instr,
  input  logic        i_instr_valid,
  input  logic        i_flush,
  output logic        o_stall,
  output logic [31:0] o_cp_word,
  output logic        o_cp_dav,
  input  logic        i_cp_done,
  output logic        o_retire,
  output logic        o_und
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] COUNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [31:0]   cp_word_next;
  logic          cp_dav_next;
  logic          retire_next;
  logic          und_next;

  logic live;
  logic cpop;
  logic cpbad;
  logic present;
  logic issue_req;
  logic trap_req;

  // Decode of the issue-stage instruction; a flush kills both issue and trap.
  assign live      = i_instr_valid & ~i_flush;
  assign cpop      = live & (i_instr[27:24] == 4'b1110) & i_instr[4];
  assign cpbad     = live & (((i_instr[27:24] == 4'b1110) & ~i_instr[4]) |
                             (i_instr[27:25] == 3'b110));
  assign present   = CP_MASK[i_instr[11:8]];
  assign issue_req = cpop & present;
  assign trap_req  = (cpop & ~present) | cpbad;

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; ISSUE always leaves via RELEASE and GAP so the bus
  // sees dav low for at least two cycles between transactions.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (issue_req) state_next = S_ISSUE;
      S_ISSUE:   if (i_cp_done || (count_reg == COUNT_LAST)) state_next = S_RELEASE;
      S_RELEASE: state_next = S_GAP;
      S_GAP:     state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and the timeout counter.
  always_comb begin
    cp_word_next = o_cp_word;
    cp_dav_next  = o_cp_dav;
    retire_next  = 1'b0;
    und_next     = 1'b0;
    count_next   = count_reg;
    case (state_reg)
      S_IDLE: begin
        if (issue_req) begin
          cp_word_next = i_instr;
          cp_dav_next  = 1'b1;
          count_next   = '0;
        end else if (trap_req) begin
          und_next = 1'b1;
        end
      end
      S_ISSUE: begin
        // Saturating count so an oversized width can never wrap back to 0.
        if (count_reg != COUNT_MAX) count_next = count_reg + 1'b1;
        // Completion takes priority over a simultaneous timeout.
        if (i_cp_done) begin
          cp_dav_next = 1'b0;
          retire_next = 1'b1;
        end else if (count_reg == COUNT_LAST) begin
          cp_dav_next = 1'b0;
          und_next    = 1'b1;
        end
      end
      default: begin
        cp_dav_next = 1'b0;
      end
    endcase
  end

  // Output and counter registers; reset drops dav immediately.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_cp_word <= '0;
      o_cp_dav  <= 1'b0;
      o_retire  <= 1'b0;
      o_und     <= 1'b0;
      count_reg <= '0;
    end else begin
      o_cp_word <= cp_word_next;
      o_cp_dav  <= cp_dav_next;
      o_retire  <= retire_next;
      o_und     <= und_next;
      count_reg <= count_next;
    end
  end

  // Stall is combinational so the issuing instruction is frozen in the same
  // cycle it is recognised; trapping ops never stall.
  assign o_stall = i_reset_n & ((state_reg != S_IDLE) | issue_req);

endmodule
